sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO, successor to the fixed 16x8 FIFO.
//  - Configurable width and depth.
//  - Simultaneous read+write in one cycle.
//  - Occupancy count, programmable almost-full/almost-empty flags.
//  - Synchronous flush and sticky overflow/underflow error flags.
//  Sits between producer/consumer blocks in the same clock domain.
// PARAMETERS
//  WIDTH     8    data word width in bits (>=1)
//  DEPTH     16   number of entries; power of 2, >=2
//  AF_LEVEL  14   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2    almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1                  clock, all logic on posedge
//  rst           in   1                  synchronous reset, active-high
//  flush         in   1                  synchronous clear of contents, active-high
//  wr            in   1                  write request
//  din           in   WIDTH              write data
//  rd            in   1                  read request
//  dout          out  WIDTH              read data, registered
//  dout_valid    out  1                  1-cycle pulse: dout updated this cycle
//  full          out  1                  count == DEPTH
//  empty         out  1                  count == 0
//  almost_full   out  1                  count >= AF_LEVEL
//  almost_empty  out  1                  count <= AE_LEVEL
//  count         out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//  overflow      out  1                  sticky: write attempted while full
//  underflow     out  1                  sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wptr=rptr=count=0, dout=0, dout_valid=0,
//    overflow=underflow=0. empty=1, full=0, almost_empty=1, almost_full=0.
//    Memory contents are not cleared. rst has priority over all other inputs.
//  - Flush (flush=1, rst=0): same as reset for pointers, count, dout_valid.
//    dout keeps its value; overflow/underflow keep their values.
//    wr/rd are ignored that cycle.
//  - Acceptance uses the flags as they stand before the edge:
//    wr_ok = wr & ~full; rd_ok = rd & ~empty.
//  - wr_ok: mem[wptr] <= din; wptr <= wptr+1 (wraps mod DEPTH).
//  - rd_ok: dout <= mem[rptr]; rptr <= rptr+1 (wraps); dout_valid=1 next cycle.
//    Read latency is 1 clock. dout holds its value when there is no read.
//  - count update: +1 if wr_ok only; -1 if rd_ok only; unchanged if both or neither.
//  - Both wr and rd when 0<count<DEPTH: both accepted, count unchanged.
//  - Both when full: read accepted, write rejected, overflow set, count=DEPTH-1.
//  - Both when empty: write accepted, read rejected, underflow set, count=1.
//    No bypass: the written word is not returned that cycle.
//  - overflow <= 1 on wr & full; underflow <= 1 on rd & empty.
//    Cleared only by rst.
//  - full, empty, almost_* are combinational decodes of the registered count.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally.
//    count is one bit wider to represent DEPTH.
// TESTING (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
//  1. Reset, then write 0x00..0x0F in 16 cycles
//     -> count=16, full=1, almost_full=1 from count 14.
//     Read 16 -> dout 0x00..0x0F in order, each 1 cycle after rd; empty=1.
//  2. Full, then wr=1 din=0xAA -> count stays 16, overflow=1.
//     Read all -> 0xAA never appears.
//  3. Empty, then rd=1 -> dout unchanged, dout_valid=0, underflow=1.
//     Then wr+rd same cycle -> count=1, underflow stays 1.
//  4. count=8, then wr+rd for 20 cycles (pointer wrap)
//     -> count stays 8, output order matches input order.
//  5. Full with wr+rd in one cycle -> count=15, overflow=1, dout=oldest word.
//  6. count=5, dout=0x33, overflow=1; assert flush
//     -> count=0, empty=1, dout=0x33, overflow=1.
//     Then assert rst -> overflow=0, dout=0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// synchronous flush and sticky overflow/underflow error flags.
module sync_fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic wr_ok;
   logic rd_ok;
   logic mem_we;

   // Status flags decode the registered count only, so they never glitch on inputs.
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));

   assign wr_ok  = wr & ~full  & ~flush;
   assign rd_ok  = rd & ~empty & ~flush;
   assign mem_we = wr_ok & ~rst;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;

      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_ok) wptr_d = wptr_q + AW'(1);
         if (rd_ok) begin
            rptr_d       = rptr_q + AW'(1);
            dout_d       = mem_q[rptr_q];
            dout_valid_d = 1'b1;
         end
         unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (wr & full)  overflow_d  = 1'b1;
         if (rd & empty) underflow_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // NOTE: storage has no reset; stale words are unreachable because pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wptr_q] <= din;
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at WIDTH=8, DEPTH=16,
// AF_LEVEL=14, AE_LEVEL=2; expected values are hand-derived per scenario.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst, flush, wr, rd;
   logic [7:0] din;
   logic [7:0] dout;
   logic       dout_valid, full, empty, almost_full, almost_empty;
   logic [4:0] count;
   logic       overflow, underflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(
      .WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .wr(wr), .din(din), .rd(rd),
      .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus, then settle just after the edge for checking.
   task automatic step(input logic w, input logic r, input logic [7:0] d);
      wr  = w;
      rd  = r;
      din = d;
      @(posedge clk);
      #1;
      wr  = 1'b0;
      rd  = 1'b0;
      din = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
      @(negedge clk);
      step(1'b1, 1'b1, 8'h77);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ae", almost_empty, 1);
      check("rst_af", almost_full, 0);
      check("rst_dout", dout, 0);
      check("rst_dv", dout_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_unf", underflow, 0);
      rst = 1'b0;

      // 1: fill 0x00..0x0F, watch flag thresholds, drain in order
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 8'(i));
         check("t1_count", count, i + 1);
         check("t1_af", almost_full, (i + 1) >= 14);
         check("t1_ae", almost_empty, (i + 1) <= 2);
         check("t1_full", full, (i + 1) == 16);
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'h00);
         check("t1_dout", dout, i);
         check("t1_dv", dout_valid, 1);
         check("t1_cnt_rd", count, 15 - i);
      end
      check("t1_empty", empty, 1);
      step(1'b0, 1'b0, 8'h00);
      check("t1_dv_idle", dout_valid, 0);
      check("t1_dout_hold", dout, 8'h0F);

      // 2: write while full is dropped and flagged
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
      step(1'b1, 1'b0, 8'hAA);
      check("t2_count", count, 16);
      check("t2_ovf", overflow, 1);
      check("t2_full", full, 1);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'h00);
         check("t2_dout", dout, 8'h10 + i);
      end
      check("t2_unf", underflow, 0);

      // 3: read while empty, then simultaneous wr+rd on empty
      step(1'b0, 1'b1, 8'h00);
      check("t3_dout", dout, 8'h1F);
      check("t3_dv", dout_valid, 0);
      check("t3_unf", underflow, 1);
      check("t3_count0", count, 0);
      step(1'b1, 1'b1, 8'h55);
      check("t3_count1", count, 1);
      check("t3_unf_sticky", underflow, 1);
      check("t3_dv_nobypass", dout_valid, 0);
      check("t3_dout_nobypass", dout, 8'h1F);
      step(1'b0, 1'b1, 8'h00);
      check("t3_dout55", dout, 8'h55);
      check("t3_count_end", count, 0);

      // 4: steady-state streaming at count=8 across pointer wrap
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
      check("t4_count8", count, 8);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 8'(8'h80 + i));
         check("t4_dout", dout, (i < 8) ? (8'h60 + i) : (8'h80 + i - 8));
         check("t4_count", count, 8);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 8'h00);
         check("t4_drain", dout, 8'h8C + i);
      end
      check("t4_empty", empty, 1);

      // 5: simultaneous wr+rd while full (overflow cleared first by reset)
      rst = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      check("t5_ovf_clr", overflow, 0);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
      step(1'b1, 1'b1, 8'hEE);
      check("t5_count", count, 15);
      check("t5_ovf", overflow, 1);
      check("t5_dout", dout, 8'hC0);
      check("t5_dv", dout_valid, 1);
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b1, 8'h00);
         check("t5_drain", dout, 8'hC1 + i);
      end
      check("t5_empty", empty, 1);

      // 6: flush keeps dout and sticky flags; reset clears them
      step(1'b1, 1'b0, 8'h33);
      step(1'b0, 1'b1, 8'h00);
      check("t6_dout33", dout, 8'h33);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
      check("t6_count5", count, 5);
      flush = 1'b1;
      step(1'b1, 1'b1, 8'h99);
      flush = 1'b0;
      check("t6_fl_count", count, 0);
      check("t6_fl_empty", empty, 1);
      check("t6_fl_dout", dout, 8'h33);
      check("t6_fl_ovf", overflow, 1);
      check("t6_fl_dv", dout_valid, 0);
      step(1'b1, 1'b0, 8'h5A);
      step(1'b0, 1'b1, 8'h00);
      check("t6_post_flush", dout, 8'h5A);
      rst = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      check("t6_rst_ovf", overflow, 0);
      check("t6_rst_dout", dout, 0);
      check("t6_rst_count", count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
